// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_ctrl
//  Purpose  : Instruction-fetch sequencer; one outstanding request to a
//             variable-latency memory, 2-entry instruction FIFO toward IF/ID.
//  Revision : 1.0
// ============================================================================
module if_fetch_ctrl #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jump_ce,
    input  logic [ADDR_W-1:0] jump_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              inst_valid
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              pend_q, pend_d;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [ADDR_W-1:0] head_pc_q, head_pc_d;
    logic [DATA_W-1:0] tail_data_q, tail_data_d;
    logic [ADDR_W-1:0] tail_pc_q, tail_pc_d;

    logic fresh;
    logic ack;
    logic push;
    logic pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_BOOT;
            fetch_pc_q  <= RESET_PC;
            req_addr_q  <= RESET_PC;
            pend_q      <= 1'b0;
            count_q     <= 2'd0;
            head_data_q <= '0;
            head_pc_q   <= '0;
            tail_data_q <= '0;
            tail_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_addr_q  <= req_addr_d;
            pend_q      <= pend_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_pc_q   <= head_pc_d;
            tail_data_q <= tail_data_d;
            tail_pc_q   <= tail_pc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_addr_d  = req_addr_q;
        pend_d      = pend_q;
        count_d     = count_q;
        head_data_d = head_data_q;
        head_pc_d   = head_pc_q;
        tail_data_d = tail_data_q;
        tail_pc_d   = tail_pc_q;

        // A new request is only launched when nothing is in flight and the FIFO has room.
        fresh    = (state_q == S_RUN) && !pend_q && (count_q < 2'd2) && !jump_ce;
        mem_req  = fresh || pend_q || (state_q == S_DROP);
        mem_addr = fresh ? fetch_pc_q : req_addr_q;
        ack      = mem_req && mem_ack;
        push     = (state_q == S_RUN) && ack && !jump_ce;
        pop      = (count_q != 2'd0) && !stall && !jump_ce;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                if (jump_ce) begin
                    fetch_pc_d = jump_pc;
                end
            end
            S_RUN: begin
                if (jump_ce) begin
                    fetch_pc_d = jump_pc;
                    if (ack) begin
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        state_d = S_DROP;
                    end
                end else if (ack) begin
                    fetch_pc_d = mem_addr + ADDR_W'(4);
                    pend_d     = 1'b0;
                end else if (fresh) begin
                    pend_d     = 1'b1;
                    req_addr_d = fetch_pc_q;
                end
            end
            S_DROP: begin
                if (jump_ce) begin
                    fetch_pc_d = jump_pc;
                end
                if (ack) begin
                    pend_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase

        if (jump_ce) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_data_d = mem_rdata;
                        head_pc_d   = mem_addr;
                    end else begin
                        tail_data_d = mem_rdata;
                        tail_pc_d   = mem_addr;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_data_d = tail_data_q;
                    head_pc_d   = tail_pc_q;
                    count_d     = count_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: the new word lands behind whatever stays.
                    if (count_q == 2'd1) begin
                        head_data_d = mem_rdata;
                        head_pc_d   = mem_addr;
                    end else begin
                        head_data_d = tail_data_q;
                        head_pc_d   = tail_pc_q;
                        tail_data_d = mem_rdata;
                        tail_pc_d   = mem_addr;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    assign inst       = head_data_q;
    assign pc_addr    = head_pc_q;
    assign inst_valid = (count_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_ctrl
//  Purpose  : Scoreboard bench for if_fetch_ctrl with a variable-latency memory.
//  Revision : 1.0
// ============================================================================
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jump_ce;
    logic [31:0] jump_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] pc_addr;
    logic        inst_valid;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_valid;

    int tests = 0;
    int fails = 0;
    int n_pop = 0;
    int fixed_lat = 0;
    int rnd_lat = 0;
    int lat_cnt = 0;

    logic [31:0] exp_q[$];
    logic [31:0] w_seen[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .jump_ce(jump_ce), .jump_pc(jump_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst(inst), .pc_addr(pc_addr), .inst_valid(inst_valid)
    );

    if_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst(rst), .stall(1'b0), .jump_ce(1'b0), .jump_pc(32'h0),
        .mem_req(w_req), .mem_addr(w_addr), .mem_ack(w_ack), .mem_rdata(w_rdata),
        .inst(w_inst), .pc_addr(w_pc), .inst_valid(w_valid)
    );

    // Memory: ack arrives after lat_cnt reaches the chosen latency (0 = same cycle).
    assign mem_ack   = mem_req && (lat_cnt >= ((fixed_lat >= 0) ? fixed_lat : rnd_lat));
    assign mem_rdata = mem_ack ? mem_word(mem_addr) : 32'hDEAD_BEEF;
    assign w_ack     = w_req;
    assign w_rdata   = mem_word(w_addr);

    always @(posedge clk) begin
        if (mem_req && !mem_ack) begin
            lat_cnt <= lat_cnt + 1;
        end else begin
            lat_cnt <= 0;
            if (mem_ack) rnd_lat <= int'($urandom_range(0, 3));
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_stream(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_jump(input logic [31:0] t);
        jump_ce = 1'b1;
        jump_pc = t;
        set_stream(t);
        tick();
        jump_ce = 1'b0;
    endtask

    task automatic wait_pending(output logic [31:0] a);
        bit ok = 1'b0;
        a = '0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (mem_req && !mem_ack && lat_cnt == 0) begin
                ok = 1'b1;
                a  = mem_addr;
            end
        end
        if (!ok) chk("wait_pending_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor: every instruction consumed by ID is compared with the program stream.
    logic [31:0] sb_e, sb_last;
    logic        p_req = 1'b0, p_ack = 1'b0, p_rst = 1'b0;
    logic [31:0] p_addr = '0;

    always @(negedge clk) begin
        if (rst === 1'b1 && inst_valid && !stall && !jump_ce) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                sb_last = exp_q[$];
                sb_e    = exp_q.pop_front();
                exp_q.push_back(sb_last + 32'd4);
                chk("sb_pc", pc_addr, sb_e);
                chk("sb_inst", inst, mem_word(sb_e));
                n_pop++;
            end
        end
        if (rst === 1'b1 && p_rst && p_req && !p_ack) begin
            chk("req_held", {31'd0, mem_req}, 32'd1);
            chk("addr_held", mem_addr, p_addr);
        end
        p_req  = mem_req;
        p_ack  = mem_ack;
        p_addr = mem_addr;
        p_rst  = (rst === 1'b1);
        if (rst === 1'b1 && w_valid && w_seen.size() < 3) w_seen.push_back(w_pc);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] t;
        rst = 1'b0; stall = 1'b0; jump_ce = 1'b0; jump_pc = '0; fixed_lat = 0;
        set_stream(32'h0);
        repeat (3) tick();
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", pc_addr, 32'd0);

        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("boot_no_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream_valid", {31'd0, inst_valid}, 32'd1);
        end

        // Stall until the FIFO fills, then release.
        tick();
        stall = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        chk("full_no_req", {31'd0, mem_req}, 32'd0);
        chk("full_valid", {31'd0, inst_valid}, 32'd1);
        tick();
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("release_valid", {31'd0, inst_valid}, 32'd1);
        end

        // Redirect while a slow request is outstanding.
        tick();
        fixed_lat = 2;
        wait_pending(a);
        tick();
        do_jump(32'h100);
        @(negedge clk);
        chk("drop_valid", {31'd0, inst_valid}, 32'd0);
        chk("drop_req", {31'd0, mem_req}, 32'd1);
        chk("drop_addr", mem_addr, a);
        @(negedge clk);
        chk("after_drop_req", {31'd0, mem_req}, 32'd1);
        chk("after_drop_addr", mem_addr, 32'h100);
        repeat (12) tick();

        // Redirect coinciding with an ack.
        fixed_lat = 1;
        wait_pending(a);
        tick();
        do_jump(32'h200);
        @(negedge clk);
        chk("jack_valid", {31'd0, inst_valid}, 32'd0);
        chk("jack_req", {31'd0, mem_req}, 32'd1);
        chk("jack_addr", mem_addr, 32'h200);
        repeat (8) tick();

        // Full FIFO, stalled, then redirect.
        fixed_lat = 0;
        stall = 1'b1;
        repeat (6) tick();
        do_jump(32'h40);
        @(negedge clk);
        chk("flush_valid", {31'd0, inst_valid}, 32'd0);
        tick();
        stall = 1'b0;
        repeat (8) tick();

        // Randomised traffic.
        fixed_lat = -1;
        for (int c = 0; c < 1500; c++) begin
            stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 4) begin
                t = $urandom() & 32'h0000_FFFC;
                jump_ce = 1'b1;
                jump_pc = t;
                set_stream(t);
            end else begin
                jump_ce = 1'b0;
            end
            tick();
        end
        jump_ce = 1'b0;
        stall = 1'b0;
        repeat (20) tick();
        chk("pops_seen", {31'd0, n_pop > 300}, 32'd1);

        // Asynchronous reset while a request is pending.
        fixed_lat = 3;
        wait_pending(a);
        #2;
        rst = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, mem_req}, 32'd0);
        chk("async_valid", {31'd0, inst_valid}, 32'd0);
        repeat (2) tick();
        set_stream(32'h0);
        fixed_lat = 0;
        rst = 1'b1;
        repeat (10) tick();

        chk("wrap_count", 32'(w_seen.size()), 32'd3);
        if (w_seen.size() == 3) begin
            chk("wrap_pc0", w_seen[0], 32'hFFFF_FFFC);
            chk("wrap_pc1", w_seen[1], 32'h0000_0000);
            chk("wrap_pc2", w_seen[2], 32'h0000_0004);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
